port_pkt_buffer: RTL and testbench

- Per-output-port store-and-forward packet buffer, directly downstream of enqueue_agent_v1. One instance per egress port; five instances total.
- Accepts AXIS beats from the pipeline bus, qualified by this port's bit of the agent's buffer write-enable vector.
- Reports almost-full back to the agent.
- Emits only fully committed packets on an AXIS master toward the output queue or scheduler.

---
 rtl/pifo_pkg.sv | 19 +
 rtl/pkt_buf_ram.sv | 23 ++
 rtl/port_pkt_buffer.sv | 135 +++++++++++++
 tb/tb_port_pkt_buffer.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pifo_pkg.sv
// rtl/pifo_pkg.sv - shared widths, port-bit offset, buffer entry and FSM state types
package pifo_pkg;

  localparam int DEF_DATA_WIDTH = 256;
  localparam int DEF_KEEP_WIDTH = 32;
  localparam int DEF_USER_WIDTH = 128;
  localparam int DST_POS        = 24;

  typedef struct packed {
    logic [DEF_DATA_WIDTH-1:0] tdata;
    logic [DEF_KEEP_WIDTH-1:0] tkeep;
    logic [DEF_USER_WIDTH-1:0] tuser;
    logic                      tlast;
  } buf_entry_t;

  typedef enum logic [1:0] {W_IDLE, W_PKT, W_DROP} wr_state_t;
  typedef enum logic [1:0] {R_IDLE, R_FILL, R_SEND} rd_state_t;

endpackage

// File: rtl/pkt_buf_ram.sv
// rtl/pkt_buf_ram.sv - simple dual-port RAM, one write port, one registered read port
module pkt_buf_ram #(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [WIDTH-1:0]      rd_data
);

  logic [WIDTH-1:0] mem [2**ADDR_WIDTH];

  // rd_data holds while rd_en is low, so it doubles as the read-side prefetch stage
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/port_pkt_buffer.sv
// rtl/port_pkt_buffer.sv - per-egress-port store-and-forward packet buffer
module port_pkt_buffer
  import pifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int KEEP_WIDTH = DEF_KEEP_WIDTH,
  parameter int USER_WIDTH = DEF_USER_WIDTH,
  parameter int ADDR_WIDTH = 9,
  parameter int AF_MARGIN  = 64
) (
  input  logic                  axis_aclk,
  input  logic                  axis_reset,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tvalid,
  input  logic                  s_wr_en,
  output logic                  m_almost_full,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic [USER_WIDTH-1:0] m_axis_tuser,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [ADDR_WIDTH:0]   m_pkt_count,
  output logic                  m_drop_sticky
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam int PW    = ADDR_WIDTH + 1;
  localparam int EW    = DATA_WIDTH + KEEP_WIDTH + USER_WIDTH + 1;

  // rd_ptr counts beats handed downstream; fetch_ptr runs ahead into the prefetch stages
  logic [PW-1:0] wr_ptr, commit_ptr, rd_ptr, fetch_ptr;
  logic [PW-1:0] wr_ptr_nxt, rd_ptr_nxt, used_nxt;
  wr_state_t     wr_state;
  rd_state_t     rd_state;
  logic          ram_vld;
  logic [EW-1:0] ram_rd_data;

  logic wr_acc, full, wr_ok, commit, overflow;
  logic out_fire, load_out, rd_issue;

  always_comb begin
    wr_acc     = s_axis_tvalid & s_wr_en;
    full       = (wr_ptr - rd_ptr) == PW'(DEPTH);
    overflow   = wr_acc & (wr_state != W_DROP) & full;
    wr_ok      = wr_acc & (wr_state != W_DROP) & !full;
    commit     = wr_ok & s_axis_tlast;
    out_fire   = m_axis_tvalid & m_axis_tready;
    load_out   = ram_vld & (!m_axis_tvalid | m_axis_tready);
    rd_issue   = (fetch_ptr != commit_ptr) & (!ram_vld | load_out);
    wr_ptr_nxt = wr_ptr;
    if (wr_ok)         wr_ptr_nxt = wr_ptr + PW'(1);
    else if (overflow) wr_ptr_nxt = commit_ptr;
    rd_ptr_nxt = rd_ptr + PW'(out_fire);
    used_nxt   = wr_ptr_nxt - rd_ptr_nxt;
  end

  pkt_buf_ram #(
    .WIDTH      (EW),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk     (axis_aclk),
    .wr_en   (wr_ok),
    .wr_addr (wr_ptr[ADDR_WIDTH-1:0]),
    .wr_data ({s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tlast}),
    .rd_en   (rd_issue),
    .rd_addr (fetch_ptr[ADDR_WIDTH-1:0]),
    .rd_data (ram_rd_data)
  );

  always_ff @(posedge axis_aclk or posedge axis_reset) begin
    if (axis_reset) begin
      wr_state      <= W_IDLE;
      wr_ptr        <= '0;
      commit_ptr    <= '0;
      m_drop_sticky <= 1'b0;
      m_almost_full <= 1'b0;
    end else begin
      wr_ptr        <= wr_ptr_nxt;
      m_almost_full <= (PW'(DEPTH) - used_nxt) < PW'(AF_MARGIN);
      if (commit)   commit_ptr    <= wr_ptr + PW'(1);
      if (overflow) m_drop_sticky <= 1'b1;
      case (wr_state)
        W_IDLE, W_PKT: begin
          if (wr_acc) wr_state <= s_axis_tlast ? W_IDLE : (full ? W_DROP : W_PKT);
        end
        W_DROP: begin
          if (wr_acc && s_axis_tlast) wr_state <= W_IDLE;
        end
        default: wr_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge axis_aclk or posedge axis_reset) begin
    if (axis_reset) begin
      rd_state      <= R_IDLE;
      rd_ptr        <= '0;
      fetch_ptr     <= '0;
      ram_vld       <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tuser  <= '0;
      m_axis_tlast  <= 1'b0;
      m_pkt_count   <= '0;
    end else begin
      rd_ptr  <= rd_ptr_nxt;
      ram_vld <= rd_issue | (ram_vld & !load_out);
      if (rd_issue) fetch_ptr <= fetch_ptr + PW'(1);
      if (load_out) begin
        {m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast} <= ram_rd_data;
        m_axis_tvalid <= 1'b1;
      end else if (out_fire) begin
        m_axis_tvalid <= 1'b0;
      end
      // a commit and a tlast hand-off in the same cycle cancel out
      case ({commit, out_fire & m_axis_tlast})
        2'b10:   m_pkt_count <= m_pkt_count + PW'(1);
        2'b01:   m_pkt_count <= m_pkt_count - PW'(1);
        default: m_pkt_count <= m_pkt_count;
      endcase
      case (rd_state)
        R_IDLE: if (rd_issue) rd_state <= R_FILL;
        R_FILL: rd_state <= R_SEND;
        R_SEND: if (out_fire && !ram_vld) rd_state <= rd_issue ? R_FILL : R_IDLE;
        default: rd_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_port_pkt_buffer.sv
// tb/tb_port_pkt_buffer.sv - randomized scoreboard bench for port_pkt_buffer
module tb_port_pkt_buffer;

  localparam int DW = 256, KW = 32, UW = 128, AW = 9, AFM = 64, DEPTH = 512;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] s_axis_tdata;
  logic [KW-1:0] s_axis_tkeep;
  logic [UW-1:0] s_axis_tuser;
  logic          s_axis_tlast, s_axis_tvalid, s_wr_en;
  logic          m_almost_full;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic [UW-1:0] m_axis_tuser;
  logic          m_axis_tlast, m_axis_tvalid, m_axis_tready;
  logic [AW:0]   m_pkt_count;
  logic          m_drop_sticky;

  always #5 clk = ~clk;

  port_pkt_buffer #(
    .DATA_WIDTH (DW), .KEEP_WIDTH (KW), .USER_WIDTH (UW),
    .ADDR_WIDTH (AW), .AF_MARGIN (AFM)
  ) dut (
    .axis_aclk     (clk),
    .axis_reset    (rst),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tvalid (s_axis_tvalid),
    .s_wr_en       (s_wr_en),
    .m_almost_full (m_almost_full),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_pkt_count   (m_pkt_count),
    .m_drop_sticky (m_drop_sticky)
  );

  typedef struct {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic [UW-1:0] u;
    logic          l;
  } beat_t;

  beat_t exp_q[$];
  beat_t part_q[$];
  int    m_occ = 0, m_pkts = 0;
  bit    m_drop = 0, m_dropping = 0;
  int    checks = 0, errors = 0, cyc = 0;
  int    tr_mode = 0;
  bit    lat_arm = 0, gap_arm = 0;
  int    lat_ref = 0, last_hs = 0, hs_n = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic beat_t rand_beat(input bit last);
    beat_t b;
    for (int i = 0; i < DW/32; i++) b.d[i*32 +: 32] = $urandom;
    for (int i = 0; i < UW/32; i++) b.u[i*32 +: 32] = $urandom;
    b.k = $urandom;
    b.l = last;
    return b;
  endfunction

  // buffer occupancy counts every stored beat until it is handed downstream
  task automatic model_beat(input beat_t b);
    if (m_dropping) begin
      if (b.l) m_dropping = 0;
    end else if (m_occ == DEPTH) begin
      m_occ -= part_q.size();
      part_q.delete();
      m_drop = 1;
      m_dropping = !b.l;
    end else begin
      part_q.push_back(b);
      m_occ++;
      if (b.l) begin
        foreach (part_q[i]) exp_q.push_back(part_q[i]);
        part_q.delete();
        m_pkts++;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_pkt(input int len, input bit en);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b = rand_beat(i == len - 1);
      s_axis_tdata = b.d; s_axis_tkeep = b.k; s_axis_tuser = b.u;
      s_axis_tlast = b.l; s_axis_tvalid = 1'b1; s_wr_en = en;
      if (b.l) lat_ref = cyc;
      @(posedge clk);
      if (en) model_beat(b);
      #1;
    end
    s_axis_tvalid = 1'b0; s_wr_en = 1'b0; s_axis_tlast = 1'b0;
  endtask

  task automatic wait_drain(input int limit);
    int n = 0;
    while ((exp_q.size() != 0 || m_pkts != 0) && n < limit) begin
      @(posedge clk); #1; n++;
    end
    if (exp_q.size() != 0 || m_pkts != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d beats still pending, expected 0", exp_q.size());
    end
    idle(3);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_tvalid", DW'(m_axis_tvalid), DW'(0));
    chk("rst_tdata", m_axis_tdata, DW'(0));
    chk("rst_tkeep", DW'(m_axis_tkeep), DW'(0));
    chk("rst_tuser", DW'(m_axis_tuser), DW'(0));
    chk("rst_tlast", DW'(m_axis_tlast), DW'(0));
    chk("rst_pkt_count", DW'(m_pkt_count), DW'(0));
    chk("rst_almost_full", DW'(m_almost_full), DW'(0));
    chk("rst_drop_sticky", DW'(m_drop_sticky), DW'(0));
  endtask

  task automatic do_reset();
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk_reset_outputs();
    exp_q.delete(); part_q.delete();
    m_occ = 0; m_pkts = 0; m_drop = 0; m_dropping = 0; lat_arm = 0; gap_arm = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    m_axis_tready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (tr_mode)
        0:       m_axis_tready = 1'b0;
        1:       m_axis_tready = 1'b1;
        default: m_axis_tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // monitor: status compares, hold-while-stalled, then pop and compare each handshake
  initial begin
    beat_t e, held;
    bit    prev_stall = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 0;
      end else begin
        chk("pkt_count", DW'(m_pkt_count), DW'(m_pkts));
        chk("almost_full", DW'(m_almost_full), DW'((DEPTH - m_occ) < AFM));
        chk("drop_sticky", DW'(m_drop_sticky), DW'(m_drop));
        if (prev_stall) begin
          chk("hold_tvalid", DW'(m_axis_tvalid), DW'(1));
          chk("hold_tdata", m_axis_tdata, held.d);
          chk("hold_tuser", DW'(m_axis_tuser), DW'(held.u));
          chk("hold_tlast", DW'(m_axis_tlast), DW'(held.l));
        end
        if (m_axis_tvalid && lat_arm) begin
          chk("first_beat_latency", DW'(cyc - lat_ref), DW'(3));
          lat_arm = 0;
        end
        if (m_axis_tvalid && m_axis_tready) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_beat: got tdata %0h, expected no beat", m_axis_tdata);
          end else begin
            e = exp_q.pop_front();
            chk("tdata", m_axis_tdata, e.d);
            chk("tkeep", DW'(m_axis_tkeep), DW'(e.k));
            chk("tuser", DW'(m_axis_tuser), DW'(e.u));
            chk("tlast", DW'(m_axis_tlast), DW'(e.l));
            if (e.l) m_pkts--;
            m_occ--;
          end
          if (gap_arm) begin
            if (hs_n > 0) chk("no_bubble", DW'(cyc - last_hs), DW'(1));
            last_hs = cyc;
            hs_n++;
          end
        end
        prev_stall = m_axis_tvalid && !m_axis_tready;
        held.d = m_axis_tdata; held.u = m_axis_tuser; held.l = m_axis_tlast;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    int  pk_before, n;
    bit  hit;
    rst = 1'b1;
    s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tuser = '0;
    s_axis_tlast = 1'b0; s_axis_tvalid = 1'b0; s_wr_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs();
    @(posedge clk); #1 rst = 1'b0;

    // single 2-beat packet, latency and ordering
    tr_mode = 1;
    idle(2);
    lat_arm = 1;
    send_pkt(2, 1);
    wait_drain(50);

    // beats without write enable are ignored
    send_pkt(3, 0);
    idle(6);
    chk("no_wr_en_tvalid", DW'(m_axis_tvalid), DW'(0));
    chk("no_wr_en_pkt_count", DW'(m_pkt_count), DW'(0));

    // two committed packets stream without a bubble
    tr_mode = 0;
    idle(2);
    send_pkt(2, 1);
    send_pkt(3, 1);
    idle(4);
    hs_n = 0;
    gap_arm = 1;
    tr_mode = 1;
    wait_drain(50);
    gap_arm = 0;
    chk("b2b_beats_seen", DW'(hs_n), DW'(5));

    // random traffic with random backpressure
    tr_mode = 2;
    for (int p = 0; p < 30; p++) begin
      send_pkt($urandom_range(1, 8), $urandom_range(0, 3) != 0);
      idle($urandom_range(0, 3));
    end
    tr_mode = 1;
    wait_drain(300);

    // almost_full threshold
    tr_mode = 0;
    idle(2);
    for (int p = 0; p < 9; p++) send_pkt(48, 1);
    send_pkt(16, 1);
    chk("af_at_448", DW'(m_almost_full), DW'(0));
    send_pkt(1, 1);
    chk("af_at_449", DW'(m_almost_full), DW'(1));
    tr_mode = 1;
    hit = 0;
    for (n = 0; n < 400 && !hit; n++) begin
      @(negedge clk); #1;
      if (exp_q.size() <= 449 - 48) hit = 1;
    end
    tr_mode = 0;
    @(posedge clk); #1;
    if (!hit) begin
      checks++; errors++;
      $display("FAIL af_drain_timeout: %0d beats pending, expected 401", exp_q.size());
    end
    chk("af_after_drain", DW'(m_almost_full), DW'(0));

    // overflow at beat 13 of a 20-beat packet
    idle(2);
    send_pkt(48, 1);
    send_pkt(48, 1);
    send_pkt(3, 1);
    pk_before = m_pkts;
    send_pkt(20, 1);
    idle(2);
    chk("overflow_drop_sticky", DW'(m_drop_sticky), DW'(1));
    chk("overflow_pkt_count", DW'(m_pkt_count), DW'(pk_before));
    tr_mode = 1;
    wait_drain(1500);
    send_pkt(5, 1);
    wait_drain(100);

    // stalled read interrupted by reset
    tr_mode = 0;
    send_pkt(4, 1);
    idle(4);
    tr_mode = 2;
    hit = 0;
    for (n = 0; n < 200 && !hit; n++) begin
      @(negedge clk); #1;
      if (exp_q.size() <= 2) hit = 1;
    end
    tr_mode = 0;
    if (!hit) begin
      checks++; errors++;
      $display("FAIL midpkt_timeout: %0d beats pending, expected 2", exp_q.size());
    end
    do_reset();
    tr_mode = 1;
    idle(2);
    send_pkt(3, 1);
    wait_drain(50);

    idle(5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
